gate_vector_checker: RTL and testbench

- Synthesizable exhaustive-stimulus and response checker for one combinational gate chip.
- Upstream role: drives every input combination onto the gate under test.
- Downstream role: consumes the gate's output and compares it against a parameterised truth table, counting mismatches.
- Replaces hand-written per-gate display benches with one reusable clocked block. Default parameters target the single-input Not gate.

---
 rtl/gate_vector_checker_pkg.sv | 20 ++
 rtl/gate_vector_checker_settle_timer.sv | 31 +++
 rtl/gate_vector_checker.sv | 136 +++++++++++++
 tb/tb_gate_vector_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_vector_checker_pkg.sv
// Shared types and helpers for the gate vector checker: FSM state encoding
// and the vector-count helper.
package gate_vector_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int vec_count(input int in_w);
    return 1 << in_w;
  endfunction

  function automatic int err_width(input int in_w);
    return in_w + 1;
  endfunction

endpackage

// File: rtl/gate_vector_checker_settle_timer.sv
// Up-counter that times how long a stimulus vector is held before sampling.
// clear has priority over en; tc flags the last settle cycle.
module settle_timer #(
  parameter int CNT_W = 2,
  parameter int TERM  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TERM);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CNT_ONE;
    end
  end

  assign tc = (count_reg == CNT_TERM);

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive stimulus generator and response checker for one combinational gate:
// walks every input vector, waits for settling, compares against a truth table.
module gate_vector_checker
  import gate_vector_checker_pkg::*;
#(
  parameter int                               IN_W          = 1,
  parameter int                               OUT_W         = 1,
  parameter logic [(2**IN_W)*OUT_W-1:0]       EXPECTED      = 2'b01,
  parameter int                               SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IN_W:0]     err_count,
  output logic [IN_W-1:0]   first_fail_vec,
  output logic              first_fail_valid
);

  localparam int N       = vec_count(IN_W);
  localparam int ERR_W   = err_width(IN_W);
  localparam int TIMER_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [IN_W-1:0]  LAST_VEC = IN_W'(N - 1);
  localparam logic [IN_W-1:0]  VEC_ONE  = IN_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_t             state_reg, state_next;
  logic [IN_W-1:0]    vec_reg, vec_next;
  logic [ERR_W-1:0]   err_reg, err_next;
  logic [IN_W-1:0]    ffv_reg, ffv_next;
  logic               ffok_reg, ffok_next;
  logic               timer_clear, timer_en, timer_tc;
  logic [OUT_W-1:0]   exp_table [N];
  logic [OUT_W-1:0]   exp_entry;
  logic               mismatch;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_table
      assign exp_table[gi] = EXPECTED[gi*OUT_W +: OUT_W];
    end
  endgenerate

  assign exp_entry = exp_table[vec_reg];
  assign mismatch  = |(dut_out ^ exp_entry);

  settle_timer #(
    .CNT_W (TIMER_W),
    .TERM  (SETTLE_CYCLES - 1)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      vec_reg   <= '0;
      err_reg   <= '0;
      ffv_reg   <= '0;
      ffok_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      vec_reg   <= vec_next;
      err_reg   <= err_next;
      ffv_reg   <= ffv_next;
      ffok_reg  <= ffok_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    vec_next    = vec_reg;
    err_next    = err_reg;
    ffv_next    = ffv_reg;
    ffok_next   = ffok_reg;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        // A restart from DONE discards the previous run's results.
        if (start) begin
          state_next  = SETTLE;
          vec_next    = '0;
          err_next    = '0;
          ffv_next    = '0;
          ffok_next   = 1'b0;
          timer_clear = 1'b1;
        end
      end
      SETTLE: begin
        timer_en = 1'b1;
        if (timer_tc) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        timer_clear = 1'b1;
        if (mismatch) begin
          err_next = err_reg + ERR_ONE;
          if (!ffok_reg) begin
            ffv_next  = vec_reg;
            ffok_next = 1'b1;
          end
        end
        if (vec_reg == LAST_VEC) begin
          state_next = DONE;
        end else begin
          vec_next   = vec_reg + VEC_ONE;
          state_next = SETTLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // dut_in is the vector register itself: zero in IDLE, last vector held in DONE.
  assign dut_in           = vec_reg;
  assign busy             = (state_reg == SETTLE) || (state_reg == CHECK);
  assign done             = (state_reg == DONE);
  assign pass             = (state_reg == DONE) && (err_reg == '0);
  assign err_count        = err_reg;
  assign first_fail_vec   = ffv_reg;
  assign first_fail_valid = ffok_reg;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: three instances (Not, And, Not with minimum
// settle) driven by table-based gate models, checked against a truth-table model.
module tb_gate_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b, start_c;

  logic       dut_in_a, out_a, busy_a, done_a, pass_a, ffv_a, ffok_a;
  logic [1:0] err_a;
  logic [1:0] dut_in_b, ffv_b;
  logic       out_b, busy_b, done_b, pass_b, ffok_b;
  logic [2:0] err_b;
  logic       dut_in_c, out_c, busy_c, done_c, pass_c, ffv_c, ffok_c;
  logic [1:0] err_c;

  logic resp_a [2];
  logic resp_b [4];
  logic resp_c [2];

  assign out_a = resp_a[dut_in_a];
  assign out_b = resp_b[dut_in_b];
  assign out_c = resp_c[dut_in_c];

  gate_vector_checker u_not (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_in(dut_in_a), .dut_out(out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffv_a), .first_fail_valid(ffok_a)
  );

  gate_vector_checker #(
    .IN_W(2), .OUT_W(1), .EXPECTED(4'b1000), .SETTLE_CYCLES(2)
  ) u_and (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_in(dut_in_b), .dut_out(out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffv_b), .first_fail_valid(ffok_b)
  );

  gate_vector_checker #(
    .SETTLE_CYCLES(1)
  ) u_min (
    .clk(clk), .rst_n(rst_n), .start(start_c), .dut_in(dut_in_c), .dut_out(out_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_fail_vec(ffv_c), .first_fail_valid(ffok_c)
  );

  typedef struct {
    logic [31:0] dut_in, busy, done, pass, err, ffv, ffok;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;
  int s_of [3] = '{2, 2, 1};
  int n_of [3] = '{2, 4, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic obs_t snap(input int w);
    obs_t o;
    case (w)
      0: begin
        o.dut_in = 32'(dut_in_a); o.busy = 32'(busy_a); o.done = 32'(done_a);
        o.pass = 32'(pass_a); o.err = 32'(err_a); o.ffv = 32'(ffv_a); o.ffok = 32'(ffok_a);
      end
      1: begin
        o.dut_in = 32'(dut_in_b); o.busy = 32'(busy_b); o.done = 32'(done_b);
        o.pass = 32'(pass_b); o.err = 32'(err_b); o.ffv = 32'(ffv_b); o.ffok = 32'(ffok_b);
      end
      default: begin
        o.dut_in = 32'(dut_in_c); o.busy = 32'(busy_c); o.done = 32'(done_c);
        o.pass = 32'(pass_c); o.err = 32'(err_c); o.ffv = 32'(ffv_c); o.ffok = 32'(ffok_c);
      end
    endcase
    return o;
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Truth table of the gate each instance is meant to check: Not or 2-input And.
  function automatic int expect_entry(input int w, input int i);
    if (w == 1) return (i == 3) ? 1 : 0;
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic int resp_entry(input int w, input int i);
    case (w)
      0:       return int'(resp_a[i]);
      1:       return int'(resp_b[i]);
      default: return int'(resp_c[i]);
    endcase
  endfunction

  task automatic model(input int w, output int err, output int ffv, output int ok);
    err = 0; ffv = 0; ok = 0;
    for (int i = 0; i < n_of[w]; i++) begin
      if (resp_entry(w, i) != expect_entry(w, i)) begin
        err++;
        if (ok == 0) begin
          ffv = i;
          ok  = 1;
        end
      end
    end
  endtask

  task automatic check_reset(input int w, input string tag);
    obs_t o;
    o = snap(w);
    chk({tag, " dut_in"}, o.dut_in, 0);
    chk({tag, " busy"},   o.busy,   0);
    chk({tag, " done"},   o.done,   0);
    chk({tag, " pass"},   o.pass,   0);
    chk({tag, " err"},    o.err,    0);
    chk({tag, " ffv"},    o.ffv,    0);
    chk({tag, " ffok"},   o.ffok,   0);
  endtask

  // One full run; glitch >= 0 pulses start for the cycle after sample k (ignored while busy).
  task automatic run(input int w, input int glitch, input string tag);
    obs_t o;
    int total, k, e_err, e_ffv, e_ok;
    total = n_of[w] * (s_of[w] + 1);
    @(negedge clk); set_start(w, 1'b1);
    @(posedge clk); #1; set_start(w, 1'b0);
    o = snap(w);
    chk({tag, " launch done"}, o.done, 0);
    chk({tag, " launch pass"}, o.pass, 0);
    chk({tag, " launch err"},  o.err,  0);
    chk({tag, " launch ffok"}, o.ffok, 0);
    chk({tag, " launch busy"}, o.busy, 1);
    k = 0;
    while (o.done !== 32'd1 && k < total + 4) begin
      chk({tag, " dut_in"}, o.dut_in, 32'(k / (s_of[w] + 1)));
      set_start(w, (k == glitch) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      set_start(w, 1'b0);
      k++;
      o = snap(w);
    end
    chk({tag, " edges"}, 32'(k), 32'(total));
    model(w, e_err, e_ffv, e_ok);
    chk({tag, " err"},  o.err,  32'(e_err));
    chk({tag, " ffok"}, o.ffok, 32'(e_ok));
    chk({tag, " ffv"},  o.ffv,  32'(e_ffv));
    chk({tag, " pass"}, o.pass, (e_err == 0) ? 32'd1 : 32'd0);
    chk({tag, " busy"}, o.busy, 0);
    chk({tag, " last dut_in"}, o.dut_in, 32'(n_of[w] - 1));
    $display("run %s inst=%0d edges=%0d err=%0d ffv=%0d ffok=%0d", tag, w, k, o.err, o.ffv, o.ffok);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int tot;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    resp_a[0] = 1'b1; resp_a[1] = 1'b0;
    for (int i = 0; i < 4; i++) resp_b[i] = 1'b0;
    resp_c[0] = 1'b1; resp_c[1] = 1'b0;

    #12;
    check_reset(0, "reset not");
    check_reset(1, "reset and");
    check_reset(2, "reset min");
    @(negedge clk) rst_n = 1'b1;

    run(0, -1, "not_golden");
    repeat (3) @(posedge clk);
    #1;
    o = snap(0);
    chk("done held", o.done, 1);
    chk("pass held", o.pass, 1);
    chk("dut_in held", o.dut_in, 1);

    // Buffer in place of Not; launching from DONE also exercises restart.
    resp_a[0] = 1'b0; resp_a[1] = 1'b1;
    run(0, -1, "not_buffer");

    resp_a[0] = 1'b1; resp_a[1] = 1'b0;
    run(0, 2, "start_in_check");

    run(1, -1, "and_stuck0");
    run(2, -1, "not_min_settle");

    // Reset while in SETTLE of vector 1, with one error already recorded.
    resp_a[0] = 1'b0; resp_a[1] = 1'b1;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = snap(0);
    chk("midrun busy", o.busy, 1);
    chk("midrun dut_in", o.dut_in, 1);
    chk("midrun err", o.err, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset(0, "async reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post reset busy", 32'(busy_a), 0);
      chk("post reset done", 32'(done_a), 0);
    end
    $display("reset mid-run checked, idle for 10 cycles");

    // start held high: DONE lasts one cycle between back-to-back runs.
    @(negedge clk) start_c = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      chk("held start done", 32'(done_c), (k % 5 == 4) ? 32'd1 : 32'd0);
    end
    start_c = 1'b0;
    $display("held start checked on min-settle instance");

    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 3; w++) begin
        for (int i = 0; i < 2; i++) begin
          resp_a[i] = 1'($urandom_range(0, 1));
          resp_c[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 4; i++) resp_b[i] = 1'($urandom_range(0, 1));
        tot = n_of[w] * (s_of[w] + 1);
        run(w, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, tot - 1)) : -1, "random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
